reg_scoreboard: RTL and testbench

- Tracks in-flight register writes for the pipelined WISC core; sits beside decode and the 8-entry register file.
- Counts issued-but-not-retired writes per register and raises a stall when a decoding instruction reads a pending register (RAW hazard).
- Also raises a stall when a register's pending count would overflow (WAW depth limit).
- Consumed by the PC/fetch-decode pipeline registers as their hold signal; retirement comes from the writeback stage.

---
 rtl/wisc_pkg.sv | 14 +
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/sb_counter.sv | 48 ++++
 rtl/reg_scoreboard.sv | 77 +++++++
 tb/tb_reg_scoreboard.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC core constants and types: register file geometry and scoreboard counter width.
package wisc_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned REG_BITS = $clog2(NUM_REGS);
    localparam int unsigned CNT_BITS = 2;
    localparam int unsigned CNT_MAX  = (1 << CNT_BITS) - 1;

    typedef logic [REG_BITS-1:0] reg_sel_t;

    // Link register targeted by JAL/JALR
    localparam reg_sel_t REG_R7 = reg_sel_t'(NUM_REGS - 1);

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/flush signalling between the pipeline and the register scoreboard.
interface reg_scoreboard_if;

    logic                          issue_valid;
    logic                          issue_wr_en;
    wisc_pkg::reg_sel_t            issue_wr_reg;
    logic                          src1_valid;
    wisc_pkg::reg_sel_t            src1_reg;
    logic                          src2_valid;
    wisc_pkg::reg_sel_t            src2_reg;
    logic                          retire_valid;
    wisc_pkg::reg_sel_t            retire_reg;
    logic                          flush;
    logic                          stall;
    logic                          issue_ack;
    logic [wisc_pkg::NUM_REGS-1:0] busy_vec;
    logic                          err;

    modport master (
        output issue_valid, issue_wr_en, issue_wr_reg,
        output src1_valid, src1_reg, src2_valid, src2_reg,
        output retire_valid, retire_reg, flush,
        input  stall, issue_ack, busy_vec, err
    );

    modport slave (
        input  issue_valid, issue_wr_en, issue_wr_reg,
        input  src1_valid, src1_reg, src2_valid, src2_reg,
        input  retire_valid, retire_reg, flush,
        output stall, issue_ack, busy_vec, err
    );

endinterface

// File: rtl/sb_counter.sv
// Saturating-free pending-write counter for one register; clear dominates, inc+dec cancels.
module sb_counter
    import wisc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] cnt,
    output logic                nz,
    output logic                at_max,
    output logic                underflow
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Overflow is prevented upstream by the full stall, so inc never wraps
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_BITS'(1);
            end
        end
    end

    assign cnt    = cnt_q;
    assign nz     = (cnt_q != '0);
    assign at_max = (cnt_q == CNT_BITS'(CNT_MAX));

endmodule

// File: rtl/reg_scoreboard.sv
// RAW/WAW hazard scoreboard for the WISC decode stage.
// Define REG_SCOREBOARD_RETIRE_BYPASS_EN to let a same-cycle retire clear a RAW hazard.
module reg_scoreboard
    import wisc_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    logic [CNT_BITS-1:0] cnt     [NUM_REGS];
    logic [CNT_BITS-1:0] eff_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    logic hit1_c;
    logic hit2_c;
    logic full_c;
    logic stall_c;
    logic ack_c;
    logic err_q;
    logic err_d;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign inc[r] = ack_c & sb.issue_wr_en & (sb.issue_wr_reg == reg_sel_t'(r));
        assign dec[r] = sb.retire_valid & (sb.retire_reg == reg_sel_t'(r));

`ifdef REG_SCOREBOARD_RETIRE_BYPASS_EN
        // Register file forwards the retiring value, so its last pending write is already visible
        assign eff_cnt[r] = (dec[r] && nz[r]) ? cnt[r] - CNT_BITS'(1) : cnt[r];
`else
        assign eff_cnt[r] = cnt[r];
`endif

        sb_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clr       (sb.flush),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .cnt       (cnt[r]),
            .nz        (nz[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    // Full check deliberately uses the raw count, never the bypassed one
    always_comb begin
        hit1_c  = sb.src1_valid & (eff_cnt[sb.src1_reg] != '0);
        hit2_c  = sb.src2_valid & (eff_cnt[sb.src2_reg] != '0);
        full_c  = sb.issue_wr_en & at_max[sb.issue_wr_reg];
        stall_c = sb.issue_valid & ~sb.flush & (hit1_c | hit2_c | full_c);
        ack_c   = sb.issue_valid & ~sb.flush & ~stall_c;
    end

    always_comb begin
        err_d = err_q | (|underflow);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sb.stall     = stall_c;
    assign sb.issue_ack = ack_c;
    assign sb.busy_vec  = nz;
    assign sb.err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios plus random traffic vs a pending-count model.
module tb_reg_scoreboard;
    import wisc_pkg::*;

    typedef struct {
        bit       stall;
        bit       ack;
        bit [7:0] busy;
        bit       err;
        int       idx;
    } exp_t;

    logic clk;
    logic rst;
    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_idx = 0;
    exp_t exp_q[$];
    int   pend[8];
    bit   err_m;

`ifdef REG_SCOREBOARD_RETIRE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against whatever the driver queued
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",     e.idx, 32'(sb_if.stall),     32'(e.stall));
            check("issue_ack", e.idx, 32'(sb_if.issue_ack), 32'(e.ack));
            check("busy_vec",  e.idx, 32'(sb_if.busy_vec), 32'(e.busy));
            check("err",       e.idx, 32'(sb_if.err),       32'(e.err));
        end
    end

    function automatic int eff_pend(input int r, input bit rv, input int rr);
        if (BYPASS && rv && rr == r && pend[r] > 0) return pend[r] - 1;
        return pend[r];
    endfunction

    // One decode/writeback cycle; called at posedge+1, returns at next posedge+1
    task automatic cycle(input bit iv, input bit we, input int wr,
                         input bit s1v, input int s1r, input bit s2v, input int s2r,
                         input bit rv, input int rr, input bit fl);
        exp_t e;
        bit   hit;
        bit   full;
        sb_if.issue_valid  = iv;
        sb_if.issue_wr_en  = we;
        sb_if.issue_wr_reg = reg_sel_t'(wr);
        sb_if.src1_valid   = s1v;
        sb_if.src1_reg     = reg_sel_t'(s1r);
        sb_if.src2_valid   = s2v;
        sb_if.src2_reg     = reg_sel_t'(s2r);
        sb_if.retire_valid = rv;
        sb_if.retire_reg   = reg_sel_t'(rr);
        sb_if.flush        = fl;

        e.busy = '0;
        for (int r = 0; r < 8; r++) e.busy[r] = (pend[r] != 0);
        e.err  = err_m;
        hit    = (s1v && eff_pend(s1r, rv, rr) != 0) || (s2v && eff_pend(s2r, rv, rr) != 0);
        full   = we && pend[wr] == 3;
        e.stall = iv && !fl && (hit || full);
        e.ack   = iv && !fl && !e.stall;
        e.idx   = cyc_idx;
        exp_q.push_back(e);

        if (fl) begin
            for (int r = 0; r < 8; r++) pend[r] = 0;
        end else begin
            bit do_inc;
            do_inc = e.ack && we;
            if (do_inc && rv && wr == rr) begin
                // write issued and retired on the same register: net zero
            end else begin
                if (do_inc) pend[wr]++;
                if (rv) begin
                    if (pend[rr] == 0) err_m = 1'b1;
                    else pend[rr]--;
                end
            end
        end
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int r);
        cycle(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ret(input int r);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    // Assert reset between edges and check it takes effect before any clock
    task automatic async_reset();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wr_en = 1'b1;
        sb_if.src1_valid  = 1'b1;
        sb_if.src1_reg    = reg_sel_t'($urandom_range(0, 7));
        sb_if.src2_valid  = 1'b1;
        sb_if.src2_reg    = reg_sel_t'($urandom_range(0, 7));
        sb_if.flush       = 1'b0;
        sb_if.retire_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_busy_vec", cyc_idx, 32'(sb_if.busy_vec), 32'h0);
        check("rst_err",      cyc_idx, 32'(sb_if.err),      32'h0);
        check("rst_stall",    cyc_idx, 32'(sb_if.stall),    32'h0);
        #2;
        rst = 1'b1;
        for (int r = 0; r < 8; r++) pend[r] = 0;
        err_m = 1'b0;
        sb_if.issue_valid  = 1'b0;
        sb_if.src1_valid   = 1'b0;
        sb_if.src2_valid   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic random_cycle();
        bit iv, we, s1v, s2v, rv, fl;
        int wreg, s1r, s2r, rr;
        int cand[$];
        iv   = ($urandom_range(0, 3) != 0);
        we   = ($urandom_range(0, 2) != 0);
        wreg = $urandom_range(0, 7);
        s1v  = $urandom_range(0, 1);
        s2v  = $urandom_range(0, 1);
        s1r  = $urandom_range(0, 7);
        s2r  = $urandom_range(0, 7);
        fl   = ($urandom_range(0, 19) == 0);
        rv   = 1'b0;
        rr   = $urandom_range(0, 7);
        for (int r = 0; r < 8; r++) if (pend[r] != 0) cand.push_back(r);
        if (cand.size() != 0 && $urandom_range(0, 9) < 4) begin
            rv = 1'b1;
            rr = cand[$urandom_range(0, cand.size() - 1)];
        end else if ($urandom_range(0, 39) == 0) begin
            rv = 1'b1;
        end
        cycle(iv, we, wreg, s1v, s1r, s2v, s2r, rv, rr, fl);
    endtask

    initial begin
        err_m = 1'b0;
        for (int r = 0; r < 8; r++) pend[r] = 0;
        rst = 1'b0;
        sb_if.issue_valid  = 1'b0;
        sb_if.issue_wr_en  = 1'b0;
        sb_if.issue_wr_reg = '0;
        sb_if.src1_valid   = 1'b0;
        sb_if.src1_reg     = '0;
        sb_if.src2_valid   = 1'b0;
        sb_if.src2_reg     = '0;
        sb_if.retire_valid = 1'b0;
        sb_if.retire_reg   = '0;
        sb_if.flush        = 1'b0;
        #1;
        check("reset_busy_vec", 0, 32'(sb_if.busy_vec), 32'h0);
        check("reset_err",      0, 32'(sb_if.err),      32'h0);
        check("reset_stall",    0, 32'(sb_if.stall),    32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // RAW on R3: stall until retire (one more cycle without bypass)
        wr(3);
        repeat (3) cycle(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
        cycle(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        idle();

        // WAW depth limit on R5
        wr(5); wr(5); wr(5);
        wr(5);
        cycle(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        wr(5);
        ret(5); ret(5); ret(5);
        idle();

        // Issue and retire the same register in one cycle
        wr(2);
        cycle(1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        idle();
        ret(2);
        idle();

        // Flush with a valid instruction presented, retire dropped
        wr(1); wr(4); wr(int'(REG_R7));
        cycle(1, 1, 6, 1, 1, 0, 0, 1, 4, 1);
        idle();

        // Retire underflow sets sticky err
        ret(6);
        idle(); idle();
        async_reset();
        idle();

        // Async reset with R1, R3, R4, R7 pending (busy 8'h9A)
        wr(1); wr(3); wr(4); wr(7);
        idle();
        async_reset();
        idle();

        // Random traffic in bursts separated by asynchronous resets
        for (int b = 0; b < 4; b++) begin
            repeat (400) random_cycle();
            idle();
            async_reset();
        end
        idle();
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
